// File: rtl/avalon_wait_ram_pkg.sv
// ============================================================================
//  Module      : avalon_ram_pkg
//  Description : Shared types and constants for the wait-state Avalon-MM RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package avalon_ram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } ram_state_t;

    // Fibonacci taps 16,14,13,11 expressed as a mask over lfsr[15:0]
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Matches the CPU reset vector so boot code lands in word 0
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hBFC00000;

endpackage

`default_nettype wire

// File: rtl/avalon_wait_ram_if.sv
// ============================================================================
//  Module      : avalon_wait_ram_if
//  Description : Avalon-MM bus bundle between the CPU master and the RAM slave.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface avalon_wait_ram_if;

    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        bus_error;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, bus_error
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, bus_error
    );

endinterface

`default_nettype wire

// File: rtl/avalon_wait_ram_lfsr.sv
// ============================================================================
//  Module      : wait_lfsr
//  Description : Seeded 16-bit Fibonacci LFSR giving a per-transfer wait count
//                in 0..MAX_WAIT; steps once per asserted i_advance.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wait_lfsr
    import avalon_ram_pkg::*;
#(
    parameter int MAX_WAIT = 2
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_advance,
    output logic [3:0]      o_wait_count
);

    localparam logic [4:0] c_modulus = 5'(MAX_WAIT + 1);

    logic [15:0] r_lfsr;
    logic        w_feedback;
    logic [4:0]  w_mod;

    assign w_feedback = ^(r_lfsr & LFSR_TAPS);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else if (i_advance) begin
            r_lfsr <= {r_lfsr[14:0], w_feedback};
        end
    end

    // The count reflects the state before this transfer's advance
    assign w_mod        = {1'b0, r_lfsr[3:0]} % c_modulus;
    assign o_wait_count = w_mod[3:0];

endmodule

`default_nettype wire

// File: rtl/avalon_wait_ram.sv
// ============================================================================
//  Module      : avalon_wait_ram
//  Description : Avalon-MM word RAM at BASE_ADDR that stalls the master for a
//                programmable number of wait states per transfer.
//                Define AVALON_WAIT_RAM_RANDOM_WAIT_EN for LFSR-randomised waits.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module avalon_wait_ram
    import avalon_ram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  wire logic          clk,
    input  wire logic          reset,
    avalon_wait_ram_if.slave   bus
);

    localparam int c_idx_w = $clog2(DEPTH_WORDS);

    ram_state_t          r_state;
    ram_state_t          w_state_next;
    logic [3:0]          r_count;
    logic [c_idx_w-1:0]  r_index;
    logic [3:0]          r_be;
    logic                r_is_write;
    logic                r_oor;
    logic [31:0]         r_readdata;
    logic                r_bus_error;
    logic [31:0]         r_mem [DEPTH_WORDS];

    logic                w_req;
    logic                w_accept;
    logic                w_below;
    logic                w_oor;
    logic [29:0]         w_word;
    logic [3:0]          w_wait_count;
    logic                w_mem_we;
    logic                w_unused_bits;

    assign w_req   = bus.read | bus.write;

    // Word arithmetic only; the byte offset within a word is irrelevant
    assign w_below = bus.address[31:2] < BASE_ADDR[31:2];
    assign w_word  = bus.address[31:2] - BASE_ADDR[31:2];
    assign w_oor   = w_below || (w_word >= 30'(DEPTH_WORDS));
    assign w_unused_bits = &{1'b0, bus.address[1:0]};

`ifdef AVALON_WAIT_RAM_RANDOM_WAIT_EN
    wait_lfsr #(
        .MAX_WAIT     (WAIT_CYCLES)
    ) u_wait_lfsr (
        .clk          (clk),
        .rst          (reset),
        .i_advance    (w_accept),
        .o_wait_count (w_wait_count)
    );
`else
    assign w_wait_count = 4'(WAIT_CYCLES);
`endif

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_accept     = 1'b1;
                    w_state_next = (w_wait_count != 4'd0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                if (!w_req) begin
                    w_state_next = IDLE;
                end else if (r_count == 4'd1) begin
                    w_state_next = ACCESS;
                end
            end
            ACCESS:  w_state_next = w_req ? DONE : IDLE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_count     <= 4'd0;
            r_readdata  <= 32'd0;
            r_bus_error <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_count <= w_wait_count;
                        // Simultaneous read+write is a protocol error as well
                        if (w_oor || (bus.read && bus.write)) begin
                            r_bus_error <= 1'b1;
                        end
                    end
                end
                WAIT: r_count <= r_count - 4'd1;
                ACCESS: begin
                    if (w_req && !r_is_write) begin
                        r_readdata <= r_oor ? 32'd0 : r_mem[r_index];
                    end
                end
                default: ;
            endcase
        end
    end

    // Transfer attributes latched at acceptance; later bus changes are ignored
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_index    <= w_word[c_idx_w-1:0];
            r_be       <= bus.byteenable;
            r_is_write <= bus.write & ~bus.read;
            r_oor      <= w_oor;
        end
    end

    assign w_mem_we = !reset && (r_state == ACCESS) && w_req && r_is_write && !r_oor;

    // writedata is taken live at the ACCESS edge, not at acceptance
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (r_be[b]) begin
                    r_mem[r_index][8*b +: 8] <= bus.writedata[8*b +: 8];
                end
            end
        end
    end

    assign bus.waitrequest = w_req && (r_state != DONE);
    assign bus.readdata    = r_readdata;
    assign bus.bus_error   = r_bus_error;

endmodule

`default_nettype wire

// File: tb/tb_avalon_wait_ram.sv
// ============================================================================
//  Module      : tb_avalon_wait_ram
//  Description : Directed self-checking bench for avalon_wait_ram.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_avalon_wait_ram;
    import avalon_ram_pkg::*;

`ifdef AVALON_WAIT_RAM_RANDOM_WAIT_EN
    localparam int c_wait = 3;
`else
    localparam int c_wait = 2;
`endif
    localparam logic [31:0] c_base = 32'hBFC00000;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   last_wait;

    avalon_wait_ram_if bus ();

    avalon_wait_ram #(
        .BASE_ADDR   (c_base),
        .DEPTH_WORDS (1024),
        .WAIT_CYCLES (c_wait)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

`ifdef AVALON_WAIT_RAM_RANDOM_WAIT_EN
    logic [15:0] m_lfsr = 16'hACE1;
`endif

    // Expected wait states of the next accepted transfer
    function automatic int next_wait();
`ifdef AVALON_WAIT_RAM_RANDOM_WAIT_EN
        int w;
        w      = int'(m_lfsr[3:0]) % (c_wait + 1);
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        return w;
`else
        return c_wait;
`endif
    endfunction

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        bus.read = 1'b0; bus.write = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
`ifdef AVALON_WAIT_RAM_RANDOM_WAIT_EN
        m_lfsr = 16'hACE1;
`endif
    endtask

    task automatic xfer(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output logic [31:0] rdata, output int cycles);
        @(posedge clk); #1;
        bus.read = rd; bus.write = wr; bus.address = addr;
        bus.writedata = wdata; bus.byteenable = be;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (bus.waitrequest && cycles < 40);
        rdata = bus.readdata;
        if (bus.waitrequest) chk_value("timeout", 32'(cycles), 32'd0);
        @(posedge clk); #1;
        bus.read = 1'b0; bus.write = 1'b0;
    endtask

    task automatic wr_word(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] be, input string tag);
        logic [31:0] rd;
        int cyc, w;
        w = next_wait();
        xfer(1'b0, 1'b1, addr, data, be, rd, cyc);
        chk_value({tag, " wr latency"}, 32'(cyc), 32'(w + 3));
        last_wait = cyc - 3;
    endtask

    task automatic rd_word(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        logic [31:0] rd;
        int cyc, w;
        w = next_wait();
        xfer(1'b1, 1'b0, addr, 32'h0, 4'hF, rd, cyc);
        chk_value({tag, " rd latency"}, 32'(cyc), 32'(w + 3));
        chk_value({tag, " rd data"}, rd, exp);
        last_wait = cyc - 3;
    endtask

    initial begin
        reset = 1'b1;
        bus.read = 1'b0; bus.write = 1'b0; bus.address = 32'h0;
        bus.writedata = 32'h0; bus.byteenable = 4'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_value("reset waitrequest", 32'(bus.waitrequest), 32'd0);
        chk_value("reset readdata", bus.readdata, 32'd0);
        chk_value("reset bus_error", 32'(bus.bus_error), 32'd0);

`ifdef AVALON_WAIT_RAM_RANDOM_WAIT_EN
        begin
            int seq [2][$];
            for (int run = 0; run < 2; run++) begin
                apply_reset();
                for (int i = 0; i < 4; i++) begin
                    wr_word(c_base + 32'(4 * i), 32'h5EED0000 + 32'(i * 17), 4'hF, "rnd preload");
                    seq[run].push_back(last_wait);
                end
                for (int i = 0; i < 100; i++) begin
                    rd_word(c_base + 32'(4 * (i % 4)), 32'h5EED0000 + 32'((i % 4) * 17), "rnd");
                    chk_value("rnd wait range", 32'(last_wait >= 0 && last_wait <= 3), 32'd1);
                    seq[run].push_back(last_wait);
                end
            end
            for (int i = 0; i < seq[0].size(); i++) begin
                chk_value("rnd repeatable", 32'(seq[1][i]), 32'(seq[0][i]));
            end
        end
`else
        begin
            logic [31:0] rd;
            int cyc, w;

            // Full word write then read back
            wr_word(32'hBFC00010, 32'h12345678, 4'hF, "word");
            rd_word(32'hBFC00010, 32'h12345678, "word");

            // Byte lanes: single lane, no-op, and split lanes
            wr_word(32'hBFC00020, 32'hAABBCCDD, 4'hF, "lane preload");
            wr_word(32'hBFC00020, 32'h00001100, 4'b0010, "lane1");
            rd_word(32'hBFC00020, 32'hAABB11DD, "lane1");
            wr_word(32'hBFC00020, 32'hFFFFFFFF, 4'b0000, "be none");
            rd_word(32'hBFC00020, 32'hAABB11DD, "be none");
            wr_word(32'hBFC00020, 32'h77000055, 4'b1001, "lane03");
            rd_word(32'hBFC00020, 32'h77BB1155, "lane03");

            // Abort a write during WAIT; following read must see a fresh IDLE
            wr_word(32'hBFC00030, 32'hCAFEF00D, 4'hF, "abort preload");
            @(posedge clk); #1;
            bus.write = 1'b1; bus.address = 32'hBFC00030;
            bus.writedata = 32'hDEADBEEF; bus.byteenable = 4'hF;
            @(negedge clk);
            chk_value("abort idle wreq", 32'(bus.waitrequest), 32'd1);
            @(posedge clk); #1;
            @(negedge clk);
            chk_value("abort wait wreq", 32'(bus.waitrequest), 32'd1);
            @(posedge clk); #1;
            bus.write = 1'b0;
            @(negedge clk);
            chk_value("abort dropped wreq", 32'(bus.waitrequest), 32'd0);
            rd_word(32'hBFC00030, 32'hCAFEF00D, "abort");

            // read && write together: treated as read, flagged as error
            w = next_wait();
            xfer(1'b1, 1'b1, 32'hBFC00010, 32'hFFFFFFFF, 4'hF, rd, cyc);
            chk_value("rdwr latency", 32'(cyc), 32'(w + 3));
            chk_value("rdwr data", rd, 32'h12345678);
            chk_value("rdwr bus_error", 32'(bus.bus_error), 32'd1);
            rd_word(32'hBFC00010, 32'h12345678, "rdwr no write");

            apply_reset();
            chk_value("reset clears bus_error", 32'(bus.bus_error), 32'd0);

            // Out-of-range accesses and the last valid word
            wr_word(32'hBFC00000, 32'h01020304, 4'hF, "word0");
            rd_word(32'hBFC00010, 32'h12345678, "pre oor");
            rd_word(32'h00000000, 32'h00000000, "below base");
            chk_value("oor bus_error", 32'(bus.bus_error), 32'd1);
            wr_word(32'hBFC01000, 32'hFFFFFFFF, 4'hF, "above top");
            rd_word(32'hBFC00000, 32'h01020304, "no wrap");
            wr_word(32'hBFC00FFC, 32'h5A5A5A5A, 4'hF, "last word");
            rd_word(32'hBFC00FFC, 32'h5A5A5A5A, "last word");
            chk_value("bus_error sticky", 32'(bus.bus_error), 32'd1);

            // Reset in the WAIT cycle of a write
            wr_word(32'hBFC00040, 32'h11223344, 4'hF, "rst preload");
            @(posedge clk); #1;
            bus.write = 1'b1; bus.address = 32'hBFC00040;
            bus.writedata = 32'h99999999; bus.byteenable = 4'hF;
            @(posedge clk); #1;
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            bus.write = 1'b0;
            @(negedge clk);
            chk_value("midrst waitrequest", 32'(bus.waitrequest), 32'd0);
            chk_value("midrst state", 32'(dut.r_state), 32'(IDLE));
            chk_value("midrst bus_error", 32'(bus.bus_error), 32'd0);
            rd_word(32'hBFC00040, 32'h11223344, "midrst mem");
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/avalon_wait_ram.md
Name: avalon_wait_ram

Overview:
- Avalon-MM slave memory directly downstream of mips_cpu_bus.
- Consumes its address/read/write/writedata/byteenable stream and returns readdata under waitrequest.
- Inserts a programmable number of wait states to exercise CPU stall handling.
- Single-port word RAM mapped at a fixed base address (instruction and data space).

Parameters:
- BASE_ADDR, 32'hBFC00000, byte address of word 0.
- DEPTH_WORDS, 1024, number of 32-bit words (power of two).
- WAIT_CYCLES, 2, wait states per transfer (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  32  byte address from master; bits [1:0] ignored.
- read  in  1  read request.
- write  in  1  write request.
- writedata  in  32  write data.
- byteenable  in  4  byte lanes; bit n enables writedata[8n+7:8n].
- waitrequest  out  1  high while the transfer is not yet accepted.
- readdata  out  32  read data, valid in the cycle read=1 and waitrequest=0.
- bus_error  out  1  sticky error flag.

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high. Reset wins over any request in the same cycle.
- Reset values:
  - state = IDLE, wait counter = 0, readdata = 0, bus_error = 0.
  - RAM contents are not reset.
- FSM states:
  - IDLE: on read^write, latch word index = (address-BASE_ADDR)>>2 and byteenable. Load counter = WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, else ACCESS.
  - WAIT: counter decrements each cycle; at counter==1, go to ACCESS.
  - ACCESS: perform the RAM read into the readdata register, or the byte-masked write, on this edge. Go to DONE.
  - DONE: transfer completes this cycle. Go to IDLE.
- waitrequest = (read|write) && state!=DONE, combinational.
- Master-visible latency: read/write held for WAIT_CYCLES+3 cycles, with waitrequest low only in the final (DONE) cycle.
- Back-to-back: a new request presented in the cycle after DONE starts a fresh IDLE acceptance. Single outstanding transfer; no pipelining.
- Write: lanes with byteenable=0 are left unchanged. byteenable=0000 is a legal no-op that still completes.
- Read data is a full 32-bit word regardless of byteenable; lane selection belongs to the master.
- Out of range (address<BASE_ADDR or index>=DEPTH_WORDS):
  - Transfer still completes with the normal timing.
  - readdata = 0 and the write is dropped.
  - bus_error set sticky until reset.
- read && write in IDLE: protocol error. Set bus_error, treat as a read, no write.
- Abort: master deasserts read and write while in WAIT or ACCESS → return to IDLE next cycle; no write is committed if abort is seen before the ACCESS edge.
- Address/data changes during WAIT are ignored (latched at IDLE). writedata is sampled at the ACCESS edge.
- Reset mid-transfer: return to IDLE. A write not yet at its ACCESS edge is not performed.

Optional Feature:
- Macro: AVALON_WAIT_RAM_RANDOM_WAIT_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances once per accepted transfer.
  - Per-transfer wait count = lfsr[3:0] % (WAIT_CYCLES+1).
  - A count of 0 skips WAIT.
- Undefined: fixed WAIT_CYCLES wait states; no LFSR logic synthesised.

Decomposition:
- Package avalon_ram_pkg:
  - typedef enum logic[1:0] ram_state_t {IDLE, WAIT, ACCESS, DONE}.
  - LFSR_SEED and LFSR_TAPS constants.
  - Default BASE_ADDR constant shared with the CPU reset vector.
- One natural sub-module: wait_lfsr (seeded LFSR with advance enable and modulo output). Instantiated only under AVALON_WAIT_RAM_RANDOM_WAIT_EN.

Test Plan:
- WAIT_CYCLES=2. Write 32'h12345678 to 32'hBFC00010 with byteenable 1111, then read the same address. Required: each transfer has waitrequest high 4 cycles then low 1 cycle; readdata = 32'h12345678.
- Preload 32'hAABBCCDD at 32'hBFC00020. Write 32'h00001100 with byteenable 0010, then read. Required: readdata = 32'hAABB11DD.
- Read 32'h00000000 (below base). Required: completes after 5 cycles; readdata = 0; bus_error = 1 and stays 1 until reset.
- Assert write to 32'hBFC00030, drop it after 1 cycle in WAIT, then read the address. Required: old contents unchanged; FSM back in IDLE the next cycle.
- Issue reset in the WAIT cycle of a write. Required: waitrequest = 0 and state = IDLE after the edge; memory unchanged; bus_error = 0.
- With AVALON_WAIT_RAM_RANDOM_WAIT_EN defined and WAIT_CYCLES=3, run 100 reads. Required: every wait count is in 0..3; data always correct; the wait sequence is identical across two runs from reset.
